// File: rtl/gauss_line_buf_ctrl.sv
// Two-line buffer sequencer that presents 3-row column vectors to a 3x3 blur core, 1 clk latency.
// Optional GAUSS_BORDER_REPLICATE_EN: emit during PRIME, replicating the nearest valid row into missing rows.
module gauss_line_buf_ctrl #(
  parameter int COLORDEPTH = 8,
  parameter int M_DEPTH    = 3,
  parameter int LINE_LEN   = 2048,
  parameter int ADDR_W     = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [COLORDEPTH-1:0]              pix_i,
  input  logic                               dv_i,
  input  logic                               hs_i,
  input  logic                               vs_i,
  output logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_o,
  output logic                               dv_o,
  output logic                               hs_o,
  output logic                               vs_o,
  output logic [11:0]                        line_cnt_o,
  output logic                               ovf_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_e;

  // col needs one extra bit so that "line already full" is representable
  localparam logic [ADDR_W:0] COL_FULL = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W:0] COL_ONE  = (ADDR_W+1)'(1);

  state_e                             state_q, state_d;
  logic [ADDR_W:0]                    col_q, col_d;
  logic [11:0]                        line_cnt_q, line_cnt_d;
  logic                               ovf_q, ovf_d;
  logic                               dv_d1_q, vs_d1_q;
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_q, vect_d;
  logic                               dv_out_q, dv_out_d;
  logic                               hs_out_q, hs_out_d;
  logic                               vs_out_q, vs_out_d;

  logic [COLORDEPTH-1:0] lb1_mem [LINE_LEN];
  logic [COLORDEPTH-1:0] lb2_mem [LINE_LEN];
  logic [COLORDEPTH-1:0] lb1_rd, lb2_rd;
  logic [ADDR_W-1:0]     addr;
  logic                  active, frame_start, line_end, col_full, pix_acc, pix_drop;

  assign active      = (state_q != IDLE);
  assign frame_start = vs_i & ~vs_d1_q;
  assign line_end    = dv_d1_q & ~dv_i;
  assign col_full    = (col_q == COL_FULL);
  assign pix_acc     = active & dv_i & ~frame_start & ~col_full;
  assign pix_drop    = active & dv_i & ~frame_start & col_full;
  assign addr        = col_q[ADDR_W-1:0];
  assign lb1_rd      = lb1_mem[addr];
  assign lb2_rd      = lb2_mem[addr];

  // Read-first: the row above slides down into the two-rows-above memory.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb1_mem[addr] <= pix_i;
      lb2_mem[addr] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = PRIME;
      PRIME: begin
        if (frame_start) state_d = PRIME;
        else if (line_end && line_cnt_q == 12'd1) state_d = RUN;
      end
      RUN:     if (frame_start) state_d = PRIME;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dv_out_d  = 1'b0;
    hs_out_d  = 1'b0;
    vs_out_d  = 1'b0;
    vect_d[0] = pix_i;
    vect_d[1] = lb1_rd;
    vect_d[2] = lb2_rd;
    unique case (state_q)
      RUN:   dv_out_d = pix_acc;
      PRIME: begin
`ifdef GAUSS_BORDER_REPLICATE_EN
        dv_out_d = pix_acc;
        if (line_cnt_q == 12'd0) begin
          vect_d[1] = pix_i;
          vect_d[2] = pix_i;
        end else if (line_cnt_q == 12'd1) begin
          vect_d[2] = lb1_rd;
        end
`else
        dv_out_d = 1'b0;
`endif
      end
      default: dv_out_d = 1'b0;
    endcase
    if (active) begin
      hs_out_d = hs_i;
      vs_out_d = vs_i;
    end
  end

  always_comb begin
    col_d      = col_q;
    line_cnt_d = line_cnt_q;
    ovf_d      = ovf_q;
    if (frame_start) begin
      col_d      = '0;
      line_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (active) begin
      if (line_end) begin
        col_d = '0;
        if (line_cnt_q != 12'hFFF) line_cnt_d = line_cnt_q + 12'd1;
      end else if (pix_acc) begin
        col_d = col_q + COL_ONE;
      end
      if (pix_drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
      dv_d1_q    <= 1'b0;
      vs_d1_q    <= 1'b0;
      vect_q     <= '0;
      dv_out_q   <= 1'b0;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      dv_d1_q    <= dv_i;
      vs_d1_q    <= vs_i;
      vect_q     <= vect_d;
      dv_out_q   <= dv_out_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
    end
  end

  assign vect_o     = vect_q;
  assign dv_o       = dv_out_q;
  assign hs_o       = hs_out_q;
  assign vs_o       = vs_out_q;
  assign line_cnt_o = line_cnt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_gauss_line_buf_ctrl.sv
// Bench for gauss_line_buf_ctrl: directed test-plan steps plus random frames against a line-history model.
module tb_gauss_line_buf_ctrl;
  localparam int CD   = 8;
  localparam int TLEN = 8;
  localparam int TAW  = 3;
  localparam int HMAX = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [CD-1:0]     pix_i;
  logic              dv_i, hs_i, vs_i;
  logic [2:0][CD-1:0] vect_o;
  logic              dv_o, hs_o, vs_o;
  logic [11:0]       line_cnt_o;
  logic              ovf_o;

  gauss_line_buf_ctrl #(
    .COLORDEPTH(CD), .M_DEPTH(3), .LINE_LEN(TLEN), .ADDR_W(TAW)
  ) dut (
    .clk(clk), .rst(rst), .pix_i(pix_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .vect_o(vect_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .line_cnt_o(line_cnt_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int dv_hi  = 0;

  // Model: every completed line is kept as written; the row above at column c is the
  // most recent line that reached column c, two rows above is the one before that.
  bit            m_framed, m_ovf, m_pdv, m_pvs;
  int            m_lcnt, m_col, h_n;
  logic [CD-1:0] h_pix [HMAX][TLEN];
  int            h_len [HMAX];
  logic [CD-1:0] cur   [TLEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_line(input int c, input int nth);
    int seen = 0;
    for (int k = h_n - 1; k >= 0; k--) begin
      if (h_len[k] > c) begin
        seen++;
        if (seen == nth) return k;
      end
    end
    return -1;
  endfunction

  function automatic void close_line();
    if (m_col > 0 && h_n < HMAX) begin
      for (int c = 0; c < m_col; c++) h_pix[h_n][c] = cur[c];
      h_len[h_n] = m_col;
      h_n++;
    end
  endfunction

  task automatic step(input logic [CD-1:0] p, input logic dv, input logic hs, input logic vs);
    bit fs, le, acc, drop, emit, ehs, evs, k1, k2;
    int i1, i2;
    logic [CD-1:0] e1, e2;
    @(negedge clk);
    pix_i = p; dv_i = dv; hs_i = hs; vs_i = vs;
    fs   = vs && !m_pvs;
    le   = m_pdv && !dv;
    ehs  = m_framed && hs;
    evs  = m_framed && vs;
    acc  = m_framed && dv && !fs && (m_col < TLEN);
    drop = m_framed && dv && !fs && (m_col >= TLEN);
`ifdef GAUSS_BORDER_REPLICATE_EN
    emit = acc;
`else
    emit = acc && (m_lcnt >= 2);
`endif
    i1 = find_line(m_col, 1);
    i2 = find_line(m_col, 2);
    k1 = (i1 >= 0);
    k2 = (i2 >= 0);
    e1 = '0;
    e2 = '0;
    if (k1) e1 = h_pix[i1][m_col];
    if (k2) e2 = h_pix[i2][m_col];
`ifdef GAUSS_BORDER_REPLICATE_EN
    if (m_lcnt == 0) begin
      e1 = p; e2 = p; k1 = 1'b1; k2 = 1'b1;
    end else if (m_lcnt == 1) begin
      e2 = e1; k2 = k1;
    end
`endif
    if (fs) begin
      close_line();
      m_framed = 1'b1; m_col = 0; m_lcnt = 0; m_ovf = 1'b0;
    end else if (m_framed) begin
      if (le) begin
        close_line();
        m_col = 0;
        if (m_lcnt < 4095) m_lcnt++;
      end else if (acc) begin
        cur[m_col] = p;
        m_col++;
      end
      if (drop) m_ovf = 1'b1;
    end
    m_pdv = dv;
    m_pvs = vs;
    @(posedge clk);
    #1;
    chk("ctl", 32'({dv_o, hs_o, vs_o, line_cnt_o, ovf_o}), 32'({emit, ehs, evs, 12'(m_lcnt), m_ovf}));
    if (dv_o) dv_hi++;
    if (emit) begin
      chk("vect0", 32'(vect_o[0]), 32'(p));
      if (k1) chk("vect1", 32'(vect_o[1]), 32'(e1));
      if (k2) chk("vect2", 32'(vect_o[2]), 32'(e2));
    end
  endtask

  task automatic vs_pulse();
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_line(input int l, input int n, input int cc, input logic [23:0] cv, input logic cdv);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < n; c++) begin
      step(8'(16 * l + c), 1'b1, 1'b0, 1'b0);
      if (c == cc) begin
        chk("pt_dv", 32'(dv_o), 32'(cdv));
        if (cdv) chk("pt_vect", 32'(vect_o), 32'(cv));
      end
    end
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_line(input int n);
    int g;
    g = $urandom_range(1, 3);
    for (int i = 0; i < g; i++) step(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    for (int c = 0; c < n; c++) step(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b0;
    pix_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    #1;
    chk("arst_vect", 32'(vect_o), 32'(0));
    chk("arst_ctl", 32'({dv_o, hs_o, vs_o, line_cnt_o, ovf_o}), 32'(0));
    close_line();
    m_framed = 1'b0; m_lcnt = 0; m_col = 0; m_ovf = 1'b0; m_pdv = 1'b0; m_pvs = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pix_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    m_framed = 1'b0; m_ovf = 1'b0; m_pdv = 1'b0; m_pvs = 1'b0;
    m_lcnt = 0; m_col = 0; h_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vect", 32'(vect_o), 32'(0));
    chk("rst_ctl", 32'({dv_o, hs_o, vs_o, line_cnt_o, ovf_o}), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Unframed stream, mid-line reset, more unframed lines: no output expected
    rand_line(5);
    for (int c = 0; c < 4; c++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    do_reset_mid();
    rand_line(6);
    rand_line(6);

    // 4 x 8 frame, pixel = 16*line + col
    vs_pulse();
`ifdef GAUSS_BORDER_REPLICATE_EN
    send_line(0, 8, 2, 24'h020202, 1'b1);
    send_line(1, 8, 2, 24'h020212, 1'b1);
`else
    send_line(0, 8, 2, 24'h000000, 1'b0);
    send_line(1, 8, 2, 24'h000000, 1'b0);
`endif
    send_line(2, 8, 3, 24'h031323, 1'b1);
    dv_hi = 0;
    send_line(3, 8, -1, 24'h0, 1'b0);
    chk("dv_width", 32'(dv_hi), 32'(8));
    chk("lcnt_end", 32'(line_cnt_o), 32'(4));

    // Overflow: 10-pixel line into an 8-entry line memory
    vs_pulse();
    send_line(0, 8, -1, 24'h0, 1'b0);
    send_line(1, 8, -1, 24'h0, 1'b0);
    dv_hi = 0;
    send_line(2, 10, -1, 24'h0, 1'b0);
    chk("ovf_dv_cnt", 32'(dv_hi), 32'(8));
    chk("ovf_set", 32'(ovf_o), 32'(1));
    send_line(3, 8, -1, 24'h0, 1'b0);
    chk("ovf_hold", 32'(ovf_o), 32'(1));
    step('0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf_o), 32'(0));
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);

    // Frame restart at col 5 of line 3
    send_line(0, 8, -1, 24'h0, 1'b0);
    send_line(1, 8, -1, 24'h0, 1'b0);
    send_line(2, 8, -1, 24'h0, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(8'(16 * 3 + c), 1'b1, 1'b0, 1'b0);
    step(8'h35, 1'b1, 1'b0, 1'b1);
    chk("restart_lcnt", 32'(line_cnt_o), 32'(0));
    chk("restart_dv", 32'(dv_o), 32'(0));
    dv_hi = 0;
    step(8'h36, 1'b1, 1'b0, 1'b1);
    step(8'h37, 1'b1, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
    send_line(5, 8, -1, 24'h0, 1'b0);
`ifdef GAUSS_BORDER_REPLICATE_EN
    chk("prime_dv", 32'(dv_hi), 32'(10));
`else
    chk("prime_dv", 32'(dv_hi), 32'(0));
`endif
    chk("prime_lcnt", 32'(line_cnt_o), 32'(2));

    // Random frames, one aborted by a reset mid-line while emitting
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      for (int l = 0; l < 5; l++) rand_line($urandom_range(2, TLEN + 2));
      if (f == 1) begin
        for (int c = 0; c < 3; c++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
        do_reset_mid();
        rand_line(5);
        rand_line(6);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gauss_line_buf_ctrl.md
Name: gauss_line_buf_ctrl

Overview:
Line-buffer sequencer that feeds the 3x3 Gaussian blur convolution core.
- Takes a raster pixel stream with dv/hs/vs.
- Stores the previous two lines in on-chip line memories.
- Presents a 3-row column vector per pixel to the convolver, with timing strobes aligned to it.
- Tracks frame priming, line count and line-length overflow.

Parameters:
COLORDEPTH, 8, bits per pixel
M_DEPTH, 3, rows per output vector (fixed at 3; other values are unsupported)
LINE_LEN, 2048, max pixels per line; line memory depth
ADDR_W, 11, clog2(LINE_LEN); column address width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
pix_i  in  COLORDEPTH  incoming pixel, valid when dv_i=1
dv_i  in  1  data valid
hs_i  in  1  horizontal sync
vs_i  in  1  vertical sync
vect_o  out  COLORDEPTH x M_DEPTH  [0]=current row, [1]=row above, [2]=two rows above, same column
dv_o  out  1  vect_o valid
hs_o  out  1  hs_i delayed to align with vect_o
vs_o  out  1  vs_i delayed to align with vect_o
line_cnt_o  out  12  completed lines in current frame, saturates at 4095
ovf_o  out  1  sticky line-overflow flag, cleared at frame start

Behaviour:
- Reset (rst=0, async) drives every output to 0: vect_o, dv_o, hs_o, vs_o, line_cnt_o, ovf_o. FSM goes to IDLE, col address goes to 0. Memory contents are don't-care.
- Frame start = rising edge of vs_i, detected against a 1-cycle registered copy.
- Line end = falling edge of dv_i, same detection.
- Line memories: LB1 holds the row above, LB2 holds two rows above.
  - Each dv_i cycle reads both at col and writes in read-first fashion: LB1[col]<=pix_i, LB2[col]<=old LB1[col].
  - col increments per dv_i cycle.
- Line end clears col to 0 and increments line_cnt_o (saturating).
- Latency: exactly 1 clk from pix_i/dv_i/hs_i/vs_i to vect_o/dv_o/hs_o/vs_o.
  - vect_o[0] = registered pix_i.
  - vect_o[1] = LB1 read data; vect_o[2] = LB2 read data.
- FSM:
  - IDLE: dv_o=0, no memory writes. Frame start -> PRIME.
  - PRIME: writes active, dv_o=0. Leaves to RUN when line_cnt reaches 2 at a line end.
  - RUN: dv_o = dv_i delayed 1 cycle.
  - Frame start in PRIME or RUN, including mid-line: next state PRIME; col, line_cnt_o and ovf_o cleared that same cycle; dv_o forced 0 from the next cycle.
- Overflow: a dv_i cycle arriving with col=LINE_LEN is dropped (no write, dv_o=0 for that pixel) and sets ovf_o=1. ovf_o stays set until the next frame start.
- Frame start and line end in the same cycle: frame start wins; line_cnt_o becomes 0.
- Reset mid-line: all state aborts immediately; the next vs_i rising edge restarts from PRIME.
- hs_o and vs_o pass through with the 1-cycle delay in all states except IDLE, where they are 0.

Optional Feature:
GAUSS_BORDER_REPLICATE_EN
- Defined: PRIME also asserts dv_o, with missing rows replaced.
  - Line 0: vect_o[1]=vect_o[2]=vect_o[0].
  - Line 1: vect_o[2]=vect_o[1].
  - The frame emits every line; no two-line latency loss.
- Undefined: PRIME suppresses dv_o as above, and the first two lines of each frame produce no output.

Test Plan:
1. Reset with rst=0 mid-stream, then rst=1 -> all outputs 0. No dv_o until a vs_i rising edge and two full lines have passed.
2. Frame of 4 lines x 8 px, pixel value = 16*line+col -> dv_o low for lines 0-1. On line 2 col 3: vect_o = {0x23, 0x13, 0x03} ([0],[1],[2]) one cycle after input. line_cnt_o reads 4 at frame end.
3. Timing alignment -> hs_o/vs_o/dv_o equal hs_i/vs_i/dv_i delayed exactly 1 clk in RUN. dv_o pulse width equals dv_i width (8).
4. LINE_LEN=8, drive a 10-px line -> pixels 9 and 10 are dropped with dv_o=0 and ovf_o=1. ovf_o stays set until the next vs_i rise, then returns to 0.
5. vs_i rising at col 5 of line 3 -> col=0, line_cnt_o=0, FSM in PRIME. dv_o=0 for the next two lines.
6. With GAUSS_BORDER_REPLICATE_EN, run the scenario 2 frame:
   - Line 0 col 2: vect_o = {0x02, 0x02, 0x02}.
   - Line 1 col 2: vect_o = {0x12, 0x02, 0x02}.
   - dv_o is high on all 4 lines.
